// File: rtl/divider_pipe_hs_if.sv
// Handshake/bus bundle for divider_pipe_hs.
//   Input channel : a_i, a_signed_i, b_i, b_signed_i, row_i, col_i, valid_i -> ready_o
//   Output channel: q_o, r_o, div0_o, row_o, col_o, valid_o                 -> ready_i
// The slave modport is the divider's view; master is the producer/consumer side.
interface divider_pipe_hs_if #(
  parameter int unsigned A_WIDTH   = 16,
  parameter int unsigned B_WIDTH   = 16,
  parameter int unsigned FRAC_BITS = 0
);
  localparam int unsigned Q_WIDTH = A_WIDTH + FRAC_BITS;

  logic [A_WIDTH-1:0] a_i;
  logic               a_signed_i;
  logic [B_WIDTH-1:0] b_i;
  logic               b_signed_i;
  logic [15:0]        row_i;
  logic [15:0]        col_i;
  logic               valid_i;
  logic               ready_o;
  logic [Q_WIDTH:0]   q_o;
  logic [B_WIDTH:0]   r_o;
  logic               div0_o;
  logic [15:0]        row_o;
  logic [15:0]        col_o;
  logic               valid_o;
  logic               ready_i;

  modport slave (
    input  a_i, a_signed_i, b_i, b_signed_i, row_i, col_i, valid_i, ready_i,
    output ready_o, q_o, r_o, div0_o, row_o, col_o, valid_o
  );

  modport master (
    output a_i, a_signed_i, b_i, b_signed_i, row_i, col_i, valid_i, ready_i,
    input  ready_o, q_o, r_o, div0_o, row_o, col_o, valid_o
  );
endinterface

// File: rtl/divider_pipe_hs.sv
// Pipelined signed/unsigned restoring divider with valid/ready backpressure.
// Ports:
//   clk_i    clock
//   rst_n_i  synchronous active-low reset
//   bus      divider_pipe_hs_if.slave: operands + row/col tags in, quotient/remainder/div0 out
// Quotient has FRAC_BITS fractional bits (dividend implicitly << FRAC_BITS), truncated toward
// zero; remainder takes the dividend's sign. Latency NSTAGE+2, one sample per clock. The whole
// pipe stalls together whenever the output holds a sample that downstream refuses.
module divider_pipe_hs #(
  parameter int unsigned A_WIDTH        = 16,
  parameter int unsigned B_WIDTH        = 16,
  parameter int unsigned FRAC_BITS      = 0,
  parameter int unsigned BITS_PER_STAGE = 1
) (
  input logic              clk_i,
  input logic              rst_n_i,
  divider_pipe_hs_if.slave bus
);
  localparam int unsigned Q_WIDTH   = A_WIDTH + FRAC_BITS;
  localparam int unsigned NSTAGE    = (Q_WIDTH + BITS_PER_STAGE - 1) / BITS_PER_STAGE;
  localparam int unsigned LAST_BITS = (Q_WIDTH % BITS_PER_STAGE == 0) ? BITS_PER_STAGE :
                                      Q_WIDTH % BITS_PER_STAGE;
  localparam int unsigned R_WIDTH   = B_WIDTH + 1;

  // Index 0 is the operand-capture stage, 1..NSTAGE the division stages.
  // num_q starts as the dividend magnitude; dividend bits shift out of the MSB while quotient
  // bits shift in at the LSB, so after the last stage it holds the quotient magnitude.
  logic [Q_WIDTH-1:0] num_q   [NSTAGE+1];
  logic [R_WIDTH-1:0] rem_q   [NSTAGE+1];
  logic [R_WIDTH-1:0] den_q   [NSTAGE+1];
  logic               qneg_q  [NSTAGE+1];
  logic               rneg_q  [NSTAGE+1];
  logic               div0_q  [NSTAGE+1];
  logic [15:0]        row_q   [NSTAGE+1];
  logic [15:0]        col_q   [NSTAGE+1];
  logic               valid_q [NSTAGE+1];

  logic [Q_WIDTH:0]   q_out_q, q_out_d;
  logic [R_WIDTH-1:0] r_out_q, r_out_d;
  logic               div0_out_q, valid_out_q;
  logic [15:0]        row_out_q, col_out_q;

  logic               en;
  logic               a_neg, b_neg;
  logic [A_WIDTH-1:0] a_mag;
  logic [B_WIDTH-1:0] b_mag;

  assign en          = ~valid_out_q | bus.ready_i;
  assign bus.ready_o = en;

  // Magnitudes: negating the most negative value wraps to 2^(W-1), which is exact unsigned.
  always_comb begin
    a_neg = bus.a_signed_i & bus.a_i[A_WIDTH-1];
    b_neg = bus.b_signed_i & bus.b_i[B_WIDTH-1];
    a_mag = a_neg ? -bus.a_i : bus.a_i;
    b_mag = b_neg ? -bus.b_i : bus.b_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      num_q[0]   <= '0;
      rem_q[0]   <= '0;
      den_q[0]   <= '0;
      qneg_q[0]  <= 1'b0;
      rneg_q[0]  <= 1'b0;
      div0_q[0]  <= 1'b0;
      row_q[0]   <= '0;
      col_q[0]   <= '0;
      valid_q[0] <= 1'b0;
    end else if (en) begin
      num_q[0]   <= Q_WIDTH'(a_mag) << FRAC_BITS;
      rem_q[0]   <= '0;
      den_q[0]   <= {1'b0, b_mag};
      qneg_q[0]  <= a_neg ^ b_neg;
      rneg_q[0]  <= a_neg;
      div0_q[0]  <= (bus.b_i == '0);
      row_q[0]   <= bus.row_i;
      col_q[0]   <= bus.col_i;
      valid_q[0] <= bus.valid_i;
    end
  end

  for (genvar i = 1; i <= NSTAGE; i++) begin : g_stage
    localparam int unsigned NBITS = (i == NSTAGE) ? LAST_BITS : BITS_PER_STAGE;

    logic [Q_WIDTH-1:0] num_nx;
    logic [R_WIDTH-1:0] rem_nx;
    logic [R_WIDTH:0]   trial;

    // Restoring step, MSB first: shift next dividend bit into the partial remainder and
    // subtract the divisor whenever it fits.
    always_comb begin
      num_nx = num_q[i-1];
      rem_nx = rem_q[i-1];
      trial  = '0;
      for (int unsigned k = 0; k < NBITS; k++) begin
        trial  = {rem_nx, num_nx[Q_WIDTH-1]};
        num_nx = {num_nx[Q_WIDTH-2:0], 1'b0};
        if (trial >= {1'b0, den_q[i-1]}) begin
          trial     = trial - {1'b0, den_q[i-1]};
          num_nx[0] = 1'b1;
        end
        rem_nx = trial[R_WIDTH-1:0];
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        num_q[i]   <= '0;
        rem_q[i]   <= '0;
        den_q[i]   <= '0;
        qneg_q[i]  <= 1'b0;
        rneg_q[i]  <= 1'b0;
        div0_q[i]  <= 1'b0;
        row_q[i]   <= '0;
        col_q[i]   <= '0;
        valid_q[i] <= 1'b0;
      end else if (en) begin
        num_q[i]   <= num_nx;
        rem_q[i]   <= rem_nx;
        den_q[i]   <= den_q[i-1];
        qneg_q[i]  <= qneg_q[i-1];
        rneg_q[i]  <= rneg_q[i-1];
        div0_q[i]  <= div0_q[i-1];
        row_q[i]   <= row_q[i-1];
        col_q[i]   <= col_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Sign restore. Divide-by-zero yields the largest magnitude with the dividend's sign.
  always_comb begin
    logic [Q_WIDTH:0]   q_ext;
    logic [R_WIDTH-1:0] r_ext;
    q_ext = {1'b0, num_q[NSTAGE]};
    r_ext = rem_q[NSTAGE];
    if (div0_q[NSTAGE]) begin
      q_ext   = {1'b0, {Q_WIDTH{1'b1}}};
      q_out_d = rneg_q[NSTAGE] ? -q_ext : q_ext;
      r_out_d = '0;
    end else begin
      q_out_d = qneg_q[NSTAGE] ? -q_ext : q_ext;
      r_out_d = rneg_q[NSTAGE] ? -r_ext : r_ext;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      q_out_q     <= '0;
      r_out_q     <= '0;
      div0_out_q  <= 1'b0;
      row_out_q   <= '0;
      col_out_q   <= '0;
      valid_out_q <= 1'b0;
    end else if (en) begin
      q_out_q     <= q_out_d;
      r_out_q     <= r_out_d;
      div0_out_q  <= div0_q[NSTAGE];
      row_out_q   <= row_q[NSTAGE];
      col_out_q   <= col_q[NSTAGE];
      valid_out_q <= valid_q[NSTAGE];
    end
  end

  assign bus.q_o     = q_out_q;
  assign bus.r_o     = r_out_q;
  assign bus.div0_o  = div0_out_q;
  assign bus.row_o   = row_out_q;
  assign bus.col_o   = col_out_q;
  assign bus.valid_o = valid_out_q;
endmodule
